// File: rtl/issue_pkg.sv
// Shared constants, field positions and FSM states for the Tomasulo issue front end.
package issue_pkg;

  localparam int WORD_SIZE = 32;
  localparam int REG_SIZE  = 6;
  localparam int INSTR_W   = 64;

  localparam logic [2:0] UNIT_LW  = 3'd0;
  localparam logic [2:0] UNIT_SW  = 3'd1;
  localparam logic [2:0] UNIT_ADD = 3'd2;
  localparam logic [2:0] UNIT_MUL = 3'd3;
  localparam logic [2:0] UNIT_MV  = 3'd4;

  localparam int UNIT_HI    = 63;
  localparam int UNIT_LO    = 61;
  localparam int HASIMM_BIT = 60;
  localparam int REG1_HI    = 59;
  localparam int REG1_LO    = 54;
  localparam int REG2_HI    = 53;
  localparam int REG2_LO    = 48;
  localparam int REG3_HI    = 47;
  localparam int REG3_LO    = 42;
  localparam int RSVD_HI    = 41;
  localparam int RSVD_LO    = 32;
  localparam int IMM_HI     = 31;
  localparam int IMM_LO     = 0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    ACK   = 2'd2,
    WAIT  = 2'd3
  } state_t;

  function automatic logic unit_valid(input logic [2:0] unit);
    return (unit <= UNIT_MV);
  endfunction

endpackage

// File: rtl/issue_fifo.sv
// Instruction FIFO: power-of-two depth, separate occupancy counter, synchronous flush.
module issue_fifo
  import issue_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int WIDTH = INSTR_W,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [WIDTH-1:0] next_head,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    rd_ptr_r;
  logic [AW-1:0]    wr_ptr_r;
  logic [CW-1:0]    count_r;
  logic             do_push_s;
  logic             do_pop_s;
  logic [AW-1:0]    rd_next_s;

  assign full      = (count_r == CW'(DEPTH));
  assign empty     = (count_r == CW'(0));
  assign do_push_s = push && !full && !flush;
  assign do_pop_s  = pop && !empty && !flush;
  assign rd_next_s = rd_ptr_r + AW'(1);
  assign head      = mem_r[rd_ptr_r];
  assign next_head = mem_r[rd_next_s];
  assign count     = count_r;

  // Storage, pointers and count; flush drops bookkeeping and any same-edge push.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_r <= '0;
      wr_ptr_r <= '0;
      count_r  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else if (flush) begin
      rd_ptr_r <= '0;
      wr_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (do_push_s) begin
        mem_r[wr_ptr_r] <= din;
        wr_ptr_r        <= wr_ptr_r + AW'(1);
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_next_s;
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/issue_unit.sv
// In-order issue front end: FIFO plus DRIVE/ACK handshake FSM toward the reservation stations.
// Optional ISSUE_STATS_EN adds accepted/rejected issue counters.
module issue_unit
  import issue_pkg::*;
#(
  parameter int DEPTH      = 8,
  parameter int RETRY_WAIT = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  input  logic                in_valid,
  input  logic [INSTR_W-1:0]  in_instr,
  output logic                in_ready,
  output logic [2:0]          rs_unit,
  output logic [REG_SIZE-1:0] rs_reg1,
  output logic [REG_SIZE-1:0] rs_reg2,
  output logic [REG_SIZE-1:0] rs_reg3,
  output logic                rs_hasimm,
  output logic [WORD_SIZE-1:0] rs_imm,
  output logic                rs_enable,
  input  logic                rs_out,
  output logic                bad_op
`ifdef ISSUE_STATS_EN
  ,
  output logic [31:0]         issued_cnt,
  output logic [31:0]         full_cnt
`endif
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int RW = (RETRY_WAIT < 1) ? 1 : $clog2(RETRY_WAIT + 1);
  localparam logic [RW-1:0] RETRY_LOAD = RW'(RETRY_WAIT);

  state_t               state_r;
  state_t               state_s;
  logic [RW-1:0]        retry_r;
  logic [RW-1:0]        retry_s;
  logic [INSTR_W-1:0]   head_s;
  logic [INSTR_W-1:0]   next_head_s;
  logic [INSTR_W-1:0]   load_word_s;
  logic [CW-1:0]        count_s;
  logic                 full_s;
  logic                 empty_s;
  logic                 pop_s;
  logic                 load_s;
  logic                 bad_op_s;
  logic                 unused_s;

  logic [2:0]           rs_unit_r;
  logic [REG_SIZE-1:0]  rs_reg1_r;
  logic [REG_SIZE-1:0]  rs_reg2_r;
  logic [REG_SIZE-1:0]  rs_reg3_r;
  logic                 rs_hasimm_r;
  logic [WORD_SIZE-1:0] rs_imm_r;
  logic                 rs_enable_r;
  logic                 bad_op_r;

  issue_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (INSTR_W)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .push      (in_valid),
    .din       (in_instr),
    .pop       (pop_s),
    .head      (head_s),
    .next_head (next_head_s),
    .count     (count_s),
    .full      (full_s),
    .empty     (empty_s)
  );

  assign in_ready  = !full_s;
  assign unused_s  = ^load_word_s[RSVD_HI:RSVD_LO];

  // Next-state, pop and field-load decisions of the issue handshake.
  always_comb begin
    state_s     = state_r;
    retry_s     = retry_r;
    pop_s       = 1'b0;
    load_s      = 1'b0;
    load_word_s = head_s;
    bad_op_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (!empty_s) begin
          if (unit_valid(head_s[UNIT_HI:UNIT_LO])) begin
            state_s = DRIVE;
            load_s  = 1'b1;
          end else begin
            pop_s    = 1'b1;
            bad_op_s = 1'b1;
          end
        end else begin
          state_s = IDLE;
        end
      end
      DRIVE: begin
        state_s = ACK;
      end
      ACK: begin
        if (rs_out) begin
          pop_s = 1'b1;
          // Chain straight into the next issue only when its word is already stored.
          if ((count_s > CW'(1)) && unit_valid(next_head_s[UNIT_HI:UNIT_LO])) begin
            state_s     = DRIVE;
            load_s      = 1'b1;
            load_word_s = next_head_s;
          end else begin
            state_s = IDLE;
          end
        end else if (RETRY_WAIT == 0) begin
          state_s = DRIVE;
        end else begin
          state_s = WAIT;
          retry_s = RETRY_LOAD;
        end
      end
      WAIT: begin
        if (retry_r <= RW'(1)) begin
          state_s = DRIVE;
          retry_s = '0;
        end else begin
          retry_s = retry_r - RW'(1);
        end
      end
      default: begin
        state_s = IDLE;
        retry_s = '0;
      end
    endcase
  end

  // FSM state, strobes and registered issue fields.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      retry_r     <= '0;
      rs_enable_r <= 1'b0;
      bad_op_r    <= 1'b0;
      rs_unit_r   <= '0;
      rs_reg1_r   <= '0;
      rs_reg2_r   <= '0;
      rs_reg3_r   <= '0;
      rs_hasimm_r <= 1'b0;
      rs_imm_r    <= '0;
    end else if (flush) begin
      state_r     <= IDLE;
      retry_r     <= '0;
      rs_enable_r <= 1'b0;
      bad_op_r    <= 1'b0;
    end else begin
      state_r     <= state_s;
      retry_r     <= retry_s;
      rs_enable_r <= (state_s == DRIVE);
      bad_op_r    <= bad_op_s;
      if (load_s) begin
        rs_unit_r   <= load_word_s[UNIT_HI:UNIT_LO];
        rs_reg1_r   <= load_word_s[REG1_HI:REG1_LO];
        rs_reg2_r   <= load_word_s[REG2_HI:REG2_LO];
        rs_reg3_r   <= load_word_s[REG3_HI:REG3_LO];
        rs_hasimm_r <= load_word_s[HASIMM_BIT];
        rs_imm_r    <= load_word_s[IMM_HI:IMM_LO];
      end
    end
  end

  assign rs_unit   = rs_unit_r;
  assign rs_reg1   = rs_reg1_r;
  assign rs_reg2   = rs_reg2_r;
  assign rs_reg3   = rs_reg3_r;
  assign rs_hasimm = rs_hasimm_r;
  assign rs_imm    = rs_imm_r;
  assign rs_enable = rs_enable_r;
  assign bad_op    = bad_op_r;

`ifdef ISSUE_STATS_EN
  logic [31:0] issued_cnt_r;
  logic [31:0] full_cnt_r;

  // Lifetime accept/reject counters; flush deliberately leaves them running.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issued_cnt_r <= 32'd0;
      full_cnt_r   <= 32'd0;
    end else if (state_r == ACK) begin
      if (rs_out) begin
        issued_cnt_r <= issued_cnt_r + 32'd1;
      end else begin
        full_cnt_r <= full_cnt_r + 32'd1;
      end
    end else begin
      issued_cnt_r <= issued_cnt_r;
      full_cnt_r   <= full_cnt_r;
    end
  end

  assign issued_cnt = issued_cnt_r;
  assign full_cnt   = full_cnt_r;
`endif

endmodule

// File: tb/tb_issue_unit.sv
// Directed self-checking bench for issue_unit (DEPTH=8, RETRY_WAIT=2).
module tb_issue_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic [63:0] in_instr = 64'd0;
  logic        in_ready;
  logic [2:0]  rs_unit;
  logic [5:0]  rs_reg1, rs_reg2, rs_reg3;
  logic        rs_hasimm;
  logic [31:0] rs_imm;
  logic        rs_enable;
  logic        rs_out = 1'b0;
  logic        bad_op;
`ifdef ISSUE_STATS_EN
  logic [31:0] issued_cnt, full_cnt;
  logic [31:0] ic0, fc0;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  issue_unit #(.DEPTH(8), .RETRY_WAIT(2)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_instr(in_instr), .in_ready(in_ready),
    .rs_unit(rs_unit), .rs_reg1(rs_reg1), .rs_reg2(rs_reg2), .rs_reg3(rs_reg3),
    .rs_hasimm(rs_hasimm), .rs_imm(rs_imm), .rs_enable(rs_enable),
    .rs_out(rs_out), .bad_op(bad_op)
`ifdef ISSUE_STATS_EN
    , .issued_cnt(issued_cnt), .full_cnt(full_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] mk(input logic [2:0] u, input logic h, input logic [5:0] r1,
                                     input logic [5:0] r2, input logic [5:0] r3, input logic [31:0] imm);
    return {u, h, r1, r2, r3, 10'b0, imm};
  endfunction

  // Station-side monitor: an issue counts as accepted when rs_out is high in the cycle after the strobe.
  int         en_cnt = 0;
  int         bad_cnt = 0;
  logic       pend = 1'b0;
  logic [2:0] pend_unit = 3'd0;
  logic [5:0] pend_reg1 = 6'd0;
  logic [2:0] acc_unit_q[$];
  logic [5:0] acc_reg1_q[$];

  always @(negedge clk) begin
    if (pend && rs_out) begin
      acc_unit_q.push_back(pend_unit);
      acc_reg1_q.push_back(pend_reg1);
    end
    pend      <= rs_enable;
    pend_unit <= rs_unit;
    pend_reg1 <= rs_reg1;
    if (rs_enable) en_cnt <= en_cnt + 1;
    if (bad_op) bad_cnt <= bad_cnt + 1;
  end

  int         retry_pat[11] = '{1, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0};
  logic [2:0] bp_units[9]   = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd0, 3'd1, 3'd2, 3'd3};

  initial begin
    int k;
    int e0;
    int b0;

    // Reset values while rst_n is held low
    #2;
    check("rst_enable", rs_enable, 64'd0);
    check("rst_ready", in_ready, 64'd1);
    check("rst_bad_op", bad_op, 64'd0);
    check("rst_unit", rs_unit, 64'd0);
    check("rst_imm", rs_imm, 64'd0);
    tick; tick;
    rst_n = 1'b1;
    tick;

    // Single add issue, accepted at once
    rs_out = 1'b1;
    in_valid = 1'b1; in_instr = mk(3'b010, 1'b1, 6'd3, 6'd4, 6'd0, 32'hFFFF_FFFB);
    tick;
    in_valid = 1'b0;
    check("add_pre_en", rs_enable, 64'd0);
    tick;
    check("add_en", rs_enable, 64'd1);
    check("add_unit", rs_unit, 64'd2);
    check("add_reg1", rs_reg1, 64'd3);
    check("add_reg2", rs_reg2, 64'd4);
    check("add_hasimm", rs_hasimm, 64'd1);
    check("add_imm", rs_imm, 64'hFFFF_FFFB);
    tick;
    check("add_ack_en", rs_enable, 64'd0);
    tick;
    check("add_count", dut.u_fifo.count, 64'd0);
    check("add_state", dut.state_r, 64'd0);
    e0 = en_cnt;
    tick; tick; tick;
    check("add_no_reissue", en_cnt - e0, 64'd0);

    // Station full twice, then accepts
    acc_unit_q.delete(); acc_reg1_q.delete();
`ifdef ISSUE_STATS_EN
    ic0 = issued_cnt; fc0 = full_cnt;
`endif
    rs_out = 1'b0;
    in_valid = 1'b1; in_instr = mk(3'b010, 1'b0, 6'd5, 6'd6, 6'd7, 32'h12);
    tick;
    in_valid = 1'b0;
    for (int i = 0; i < 11; i++) begin
      tick;
      check($sformatf("retry_en%0d", i), rs_enable, retry_pat[i]);
      if (retry_pat[i] == 1) begin
        check($sformatf("retry_reg1_%0d", i), rs_reg1, 64'd5);
        check($sformatf("retry_imm_%0d", i), rs_imm, 64'h12);
      end
      if (i == 8) rs_out = 1'b1;
    end
    check("retry_count", dut.u_fifo.count, 64'd0);
    check("retry_accepts", acc_unit_q.size(), 64'd1);
`ifdef ISSUE_STATS_EN
    check("retry_full_cnt", full_cnt - fc0, 64'd2);
    check("retry_issued_cnt", issued_cnt - ic0, 64'd1);
`endif

    // Backpressure: nine back-to-back pushes while the station refuses everything
    acc_unit_q.delete(); acc_reg1_q.delete();
    rs_out = 1'b0;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; in_instr = mk(bp_units[i], 1'b0, 6'(i + 10), 6'd0, 6'd0, 32'(i));
      check($sformatf("bp_ready%0d", i), in_ready, 64'd1);
      tick;
    end
    in_instr = mk(bp_units[8], 1'b0, 6'd18, 6'd0, 6'd0, 32'd8);
    check("bp_full_ready", in_ready, 64'd0);
    check("bp_full_count", dut.u_fifo.count, 64'd8);
    tick; tick; tick;
    check("bp_held_ready", in_ready, 64'd0);
    rs_out = 1'b1;
    k = 0;
    while (!in_ready && k < 20) begin tick; k++; end
    check("bp_ready_timeout", (k < 20), 64'd1);
    tick;
    in_valid = 1'b0;
    k = 0;
    while (acc_unit_q.size() < 9 && k < 60) begin tick; k++; end
    check("bp_drain_timeout", (k < 60), 64'd1);
    check("bp_accepts", acc_unit_q.size(), 64'd9);
    for (int i = 0; i < 9; i++) begin
      if (i < acc_unit_q.size()) begin
        check($sformatf("bp_order_unit%0d", i), acc_unit_q[i], bp_units[i]);
        check($sformatf("bp_order_reg%0d", i), acc_reg1_q[i], 6'(i + 10));
      end
    end

    // Invalid opcode between two moves
    tick; tick;
    acc_unit_q.delete(); acc_reg1_q.delete();
    b0 = bad_cnt; e0 = en_cnt;
    in_valid = 1'b1; in_instr = mk(3'b100, 1'b0, 6'd1, 6'd0, 6'd0, 32'd0); tick;
    in_instr = mk(3'b110, 1'b0, 6'd9, 6'd0, 6'd0, 32'd0); tick;
    in_instr = mk(3'b100, 1'b0, 6'd2, 6'd0, 6'd0, 32'd0); tick;
    in_valid = 1'b0;
    k = 0;
    while (acc_unit_q.size() < 2 && k < 40) begin tick; k++; end
    check("badop_timeout", (k < 40), 64'd1);
    tick; tick; tick; tick;
    check("badop_pulses", bad_cnt - b0, 64'd1);
    check("badop_issues", en_cnt - e0, 64'd2);
    check("badop_accepts", acc_unit_q.size(), 64'd2);
    if (acc_unit_q.size() == 2) begin
      check("badop_u0", acc_unit_q[0], 64'd4);
      check("badop_r0", acc_reg1_q[0], 64'd1);
      check("badop_u1", acc_unit_q[1], 64'd4);
      check("badop_r1", acc_reg1_q[1], 64'd2);
    end

    // Flush in ACK with a simultaneous push
    in_valid = 1'b1; in_instr = mk(3'b010, 1'b0, 6'd7, 6'd0, 6'd0, 32'd0); tick;
    in_valid = 1'b0;
    tick;
    check("flush_drive_en", rs_enable, 64'd1);
    tick;
    flush = 1'b1; in_valid = 1'b1; in_instr = mk(3'b100, 1'b0, 6'd63, 6'd0, 6'd0, 32'd0);
    tick;
    flush = 1'b0; in_valid = 1'b0;
    check("flush_count", dut.u_fifo.count, 64'd0);
    check("flush_en", rs_enable, 64'd0);
    check("flush_ready", in_ready, 64'd1);
    check("flush_state", dut.state_r, 64'd0);
    e0 = en_cnt;
    tick; tick; tick; tick; tick;
    check("flush_no_issue", en_cnt - e0, 64'd0);

    // Asynchronous reset in the middle of DRIVE
    in_valid = 1'b1; in_instr = mk(3'b011, 1'b1, 6'd8, 6'd9, 6'd10, 32'd5); tick;
    in_valid = 1'b0;
    tick;
    check("arst_pre_en", rs_enable, 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_en", rs_enable, 64'd0);
    check("arst_unit", rs_unit, 64'd0);
    check("arst_reg1", rs_reg1, 64'd0);
    check("arst_hasimm", rs_hasimm, 64'd0);
    check("arst_imm", rs_imm, 64'd0);
    check("arst_bad_op", bad_op, 64'd0);
    check("arst_ready", in_ready, 64'd1);
    tick;
    rst_n = 1'b1;
    tick; tick;
    check("arst_post_en", rs_enable, 64'd0);
    check("arst_post_count", dut.u_fifo.count, 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/issue_unit.md
Name: issue_unit

Overview:
- Front end of the Tomasulo core.
- Buffers decoded-format instruction words in a small FIFO and drives them one at a time onto the reservation-station issue interface (unit, reg1..reg3, hasimm, imm, enable).
- Uses the station's accept bit to decide whether to pop the instruction or retry it.
- Instructions issue strictly in program order; nothing is reordered or dropped, except invalid opcodes and flushed entries.

Parameters:
- DEPTH, 8: instruction FIFO entries; power of two, minimum 2.
- RETRY_WAIT, 2: idle cycles after a rejected issue (station full) before re-driving; 0 means re-drive immediately.

Ports:
- clk  input  1  core clock; all state changes on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- flush  input  1  synchronous clear of FIFO and FSM.
- in_valid  input  1  in_instr is valid.
- in_instr  input  64  instruction word. Fields: [63:61] unit, [60] hasimm, [59:54] reg1, [53:48] reg2, [47:42] reg3, [41:32] reserved (ignored), [31:0] imm.
- in_ready  output  1  FIFO not full.
- rs_unit  output  3  000 lw, 001 sw, 010 add, 011 mul, 100 mv.
- rs_reg1, rs_reg2, rs_reg3  output  6 each  register indices.
- rs_hasimm  output  1  immediate form.
- rs_imm  output  32  signed immediate.
- rs_enable  output  1  issue strobe.
- rs_out  input  1  station accept (1) / full (0); registered by the station on the edge that samples rs_enable.
- bad_op  output  1  one-cycle pulse when an invalid opcode is discarded.

Behaviour:
- Reset (rst_n low, asynchronous): FIFO empty, state IDLE, rs_enable 0, rs_unit/regs/hasimm/imm 0, bad_op 0, in_ready 1, retry counter 0.
- Push: on the edge where in_valid && in_ready, in_instr is written at the tail. in_ready = (count != DEPTH). Push while full is impossible because in_ready is 0.
- rs_* field outputs are registered copies of the head entry, loaded on entry to DRIVE. They hold stable through DRIVE and ACK.
- FSM states:
  - IDLE: if count > 0 and head unit is valid (0..4) → DRIVE. If count > 0 and head unit is 5..7 → pop, pulse bad_op, stay IDLE.
  - DRIVE: rs_enable = 1 for exactly one cycle → ACK.
  - ACK: rs_enable = 0; sample rs_out.
    - rs_out = 1: pop head. Go to DRIVE if count after pop > 0 and the new head is valid, otherwise IDLE.
    - rs_out = 0: RETRY_WAIT = 0 → DRIVE; otherwise → WAIT with counter = RETRY_WAIT.
  - WAIT: decrement counter each cycle; at 1 → DRIVE with the same head.
- Latency: with an empty FIFO, a push at edge N puts rs_enable high in the cycle after edge N+1. The station samples at edge N+2, and the pop occurs at edge N+3.
- Throughput: one issue per 2 cycles (DRIVE/ACK alternate).
- Simultaneous push and pop in ACK: both take effect; count is unchanged. A push into an empty FIFO during IDLE is seen on the next edge.
- Pointers wrap modulo DEPTH; count is a separate (log2(DEPTH)+1)-bit register.
- flush:
  - Count, pointers, FSM (→ IDLE) and retry counter are cleared; rs_enable is deasserted the following cycle.
  - flush and push on the same edge: flush wins; the input is discarded.
  - flush while in ACK discards the head even if the station accepted it; higher-level squash owns that case.
- rs_out is ignored outside ACK.

Optional Feature:
- ISSUE_STATS_EN:
  - Defined: adds output ports issued_cnt[31:0] and full_cnt[31:0]. issued_cnt increments on each accepted issue; full_cnt increments on each rejection. Both wrap at 2^32, reset to 0, and are not cleared by flush.
  - Undefined: neither port nor counters exist; behaviour is otherwise identical.

Decomposition:
- Shared package issue_pkg:
  - unit codes UNIT_LW..UNIT_MV
  - WORD_SIZE = 32, REG_SIZE = 6, INSTR_W = 64
  - field bit positions of in_instr
  - FSM state enum {IDLE, DRIVE, ACK, WAIT}
- One sub-module: issue_fifo (parameterized DEPTH × INSTR_W, push/pop/flush, count, full/empty). The FSM lives in issue_unit.

Test Plan:
- Single add: push unit=010, reg1=3, reg2=4, hasimm=1, imm=-5. Required: rs_enable one cycle with rs_unit=010, rs_reg1=3, rs_reg2=4, rs_imm=0xFFFFFFFB; rs_out=1 → FIFO empty, state IDLE.
- Full station, RETRY_WAIT=2: rs_out=0 twice, then 1. Required: rs_enable pulses separated by 4 cycles (ACK + 2 WAIT + DRIVE), identical fields each time, one pop; full_cnt=2, issued_cnt=1 with ISSUE_STATS_EN.
- Backpressure, DEPTH=8: push 9 back-to-back while rs_out is held 0. Required: in_ready falls after the 8th push; the 9th is held until the first accept. Order lw, sw, add, mul, mv, ... is preserved on rs_unit.
- Invalid opcode: push unit=110 between two movs. Required: bad_op pulses once; only the two mv issues appear on rs_enable.
- Flush in ACK with a simultaneous push: required count=0, next cycle rs_enable=0, in_ready=1, pushed word absent.
- Async reset mid-DRIVE: rst_n low between edges. Required: rs_enable drops to 0 immediately without a clock edge, and all outputs take their reset values.
